// File: rtl/serial_subtractor_n_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// State encoding plus step-count and step-counter-width helpers.
package serial_subtractor_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_BPC   = 1;

  function automatic int stepsOf(input int w, input int bpc);
    return w / bpc;
  endfunction

  function automatic int cntWidth(input int w, input int bpc);
    return $clog2(w / bpc) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_n_if.sv
// Start/done handshake and operand/result bundle of the subtractor.
// master: start,a,b,bin out; slave: diff,bout,ovf,busy,done out.
interface serial_subtractor_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor_n_full_sub_cell.sv
// Single-bit full subtractor cell: d = a - b - c.
// Ports: a, b, c (borrow in) in; d (difference), borr (borrow out) out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic borr
);
  assign d    = a ^ b ^ c;
  assign borr = (~a & b) | (~(a ^ b) & c);
endmodule

// File: rtl/serial_subtractor_n.sv
// Multi-cycle WIDTH-bit subtractor, BPC bits per clock, start/done.
// Ports: clk, rst (async high), bus (slave). Macro: SERIAL_SUB_SAT_EN.
module serial_subtractor_n
  import serial_subtractor_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPC   = DEF_BPC
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_n_if.slave bus
);

  localparam int STEPS = stepsOf(WIDTH, BPC);
  localparam int CW    = cntWidth(WIDTH, BPC);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t state, stateNext;
  logic accept;
  logic lastStep;

  logic [WIDTH-1:0] aReg, bReg;
  logic [WIDTH-1:0] diffReg, diffNext;
  logic borrowReg, boutReg, ovfReg;
  logic [CW-1:0] stepCnt;

  logic [BPC-1:0] aSlice, bSlice, dSlice;
  logic [BPC:0]   chain;
  int off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (lastStep) stateNext = FIN;
      end
      FIN: begin
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign lastStep = (state == RUN) && (stepCnt == LAST);

  // Outside RUN the counter may sit at STEPS; pin the slice to 0.
  always_comb begin
    off    = (state == RUN) ? int'(stepCnt) * BPC : 0;
    aSlice = aReg[off +: BPC];
    bSlice = bReg[off +: BPC];
  end

  assign chain[0] = borrowReg;

  for (genvar i = 0; i < BPC; i++) begin : gCell
    full_sub_cell uCell (
      .a    (aSlice[i]),
      .b    (bSlice[i]),
      .c    (chain[i]),
      .d    (dSlice[i]),
      .borr (chain[i+1])
    );
  end

  always_comb begin
    diffNext = diffReg;
    diffNext[off +: BPC] = dSlice;
`ifdef SERIAL_SUB_SAT_EN
    // Clamp toward the sign of the minuend on signed overflow.
    if (lastStep && (chain[BPC-1] ^ chain[BPC])) begin
      diffNext = aReg[WIDTH-1] ?
        {1'b1, {(WIDTH-1){1'b0}}} :
        {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg      <= '0;
      bReg      <= '0;
      borrowReg <= 1'b0;
      stepCnt   <= '0;
      diffReg   <= '0;
      boutReg   <= 1'b0;
      ovfReg    <= 1'b0;
    end else if (accept) begin
      aReg      <= bus.a;
      bReg      <= bus.b;
      borrowReg <= bus.bin;
      stepCnt   <= '0;
      diffReg   <= '0;
      boutReg   <= 1'b0;
      ovfReg    <= 1'b0;
    end else if (state == RUN) begin
      diffReg   <= diffNext;
      borrowReg <= chain[BPC];
      stepCnt   <= stepCnt + CW'(1);
      if (lastStep) begin
        boutReg <= chain[BPC];
        ovfReg  <= chain[BPC-1] ^ chain[BPC];
      end
    end
  end

  assign bus.diff = diffReg;
  assign bus.bout = boutReg;
  assign bus.ovf  = ovfReg;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == FIN);

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Self-checking bench for serial_subtractor_n.
// Directed cases on W=8 and a random sweep on W=16 over all BPC.
module tb_serial_subtractor_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  serial_subtractor_n_if #(.WIDTH(8)) ifA ();
  serial_subtractor_n_if #(.WIDTH(8)) ifB ();

  serial_subtractor_n #(.WIDTH(8), .BPC(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  serial_subtractor_n #(.WIDTH(8), .BPC(4)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  logic        s16;
  logic [15:0] a16, b16;
  logic        bin16;
  logic [15:0] diff16 [5];
  logic        bout16 [5];
  logic        ovf16  [5];
  logic        busy16 [5];
  logic        done16 [5];

  for (genvar g = 0; g < 5; g++) begin : gSweep
    serial_subtractor_n_if #(.WIDTH(16)) bus ();
    assign bus.start = s16;
    assign bus.a     = a16;
    assign bus.b     = b16;
    assign bus.bin   = bin16;
    serial_subtractor_n #(.WIDTH(16), .BPC(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign diff16[g] = bus.diff;
    assign bout16[g] = bus.bout;
    assign ovf16[g]  = bus.ovf;
    assign busy16[g] = bus.busy;
    assign done16[g] = bus.done;
  end

  function automatic void refSub(
    input  int     w,
    input  longint a,
    input  longint b,
    input  longint bin,
    output longint d,
    output logic   bo,
    output logic   ov
  );
    longint m, h, r, sa, sb, sr;
    m  = longint'(1) << w;
    h  = m >> 1;
    r  = a - b - bin;
    bo = (r < 0);
    d  = ((r % m) + m) % m;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    sr = sa - sb - bin;
    ov = (sr > h - 1) || (sr < -h);
`ifdef SERIAL_SUB_SAT_EN
    if (ov) d = (sa >= 0) ? h - 1 : h;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startA(input logic [7:0] a, b, input logic bin);
    ifA.a     = a;
    ifA.b     = b;
    ifA.bin   = bin;
    ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
  endtask

  task automatic waitA(input int expN, input string tag);
    int n;
    n = 0;
    while (ifA.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, expN);
  endtask

  task automatic checkA(input logic [7:0] a, b, input logic bin, input string tag);
    longint d;
    logic bo, ov;
    refSub(8, a, b, bin, d, bo, ov);
    chk({tag, "_diff"}, ifA.diff, d);
    chk({tag, "_bout"}, ifA.bout, bo);
    chk({tag, "_ovf"}, ifA.ovf, ov);
    chk({tag, "_busy"}, ifA.busy, 1'b0);
  endtask

  initial begin
    int seen;
    int lat [5];
    longint d;
    logic bo, ov;

    ifA.start = 1'b0; ifA.a = '0; ifA.b = '0; ifA.bin = 1'b0;
    ifB.start = 1'b0; ifB.a = '0; ifB.b = '0; ifB.bin = 1'b0;
    s16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;

    #2 rst = 1'b1;
    #2;
    chk("rst_diff", ifA.diff, 8'h00);
    chk("rst_bout", ifA.bout, 1'b0);
    chk("rst_ovf", ifA.ovf, 1'b0);
    chk("rst_busy", ifA.busy, 1'b0);
    chk("rst_done", ifA.done, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    startA(8'h5A, 8'h23, 1'b0);
    chk("t1_busy", ifA.busy, 1'b1);
    chk("t1_done0", ifA.done, 1'b0);
    waitA(8, "t1");
    checkA(8'h5A, 8'h23, 1'b0, "t1");
    chk("t1_const", ifA.diff, 8'h37);

    startA(8'h00, 8'h01, 1'b0);
    waitA(8, "t2a");
    checkA(8'h00, 8'h01, 1'b0, "t2a");
    chk("t2a_const", ifA.diff, 8'hFF);
    startA(8'h80, 8'h01, 1'b0);
    waitA(8, "t2b");
    checkA(8'h80, 8'h01, 1'b0, "t2b");
    chk("t2b_ovf1", ifA.ovf, 1'b1);

    ifB.a = 8'h10; ifB.b = 8'h0F; ifB.bin = 1'b1;
    ifB.start = 1'b1;
    tick();
    ifB.start = 1'b0;
    seen = 0;
    while (ifB.done !== 1'b1 && seen < 20) begin
      tick();
      seen++;
    end
    chk("t3_lat", seen, 2);
    chk("t3_diff", ifB.diff, 8'h00);
    chk("t3_bout", ifB.bout, 1'b0);
    chk("t3_ovf", ifB.ovf, 1'b0);

    startA(8'h5A, 8'h23, 1'b0);
    tick();
    ifA.a = 8'hFF; ifA.b = 8'h01; ifA.bin = 1'b1;
    ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    tick();
    waitA(5, "t4ign");
    checkA(8'h5A, 8'h23, 1'b0, "t4ign");
    startA(8'h10, 8'h20, 1'b1);
    chk("t4b2b_busy", ifA.busy, 1'b1);
    chk("t4b2b_done", ifA.done, 1'b0);
    chk("t4b2b_clr", ifA.diff, 8'h00);
    waitA(8, "t4b2b");
    checkA(8'h10, 8'h20, 1'b1, "t4b2b");

    startA(8'hC3, 8'h5C, 1'b0);
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_diff", ifA.diff, 8'h00);
    chk("t5_bout", ifA.bout, 1'b0);
    chk("t5_ovf", ifA.ovf, 1'b0);
    chk("t5_busy", ifA.busy, 1'b0);
    chk("t5_done", ifA.done, 1'b0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (ifA.done === 1'b1) seen++;
    end
    chk("t5_nodone", seen, 0);
    startA(8'hC3, 8'h5C, 1'b0);
    waitA(8, "t5re");
    checkA(8'hC3, 8'h5C, 1'b0, "t5re");

    for (int it = 0; it < 40; it++) begin
      if (it == 0) begin
        a16 = 16'h0000; b16 = 16'h0001; bin16 = 1'b0;
      end else if (it == 1) begin
        a16 = 16'h8000; b16 = 16'h0001; bin16 = 1'b0;
      end else if (it == 2) begin
        a16 = 16'h7FFF; b16 = 16'hFFFF; bin16 = 1'b1;
      end else begin
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        bin16 = 1'($urandom);
      end
      s16 = 1'b1;
      tick();
      s16 = 1'b0;
      for (int g = 0; g < 5; g++) lat[g] = -1;
      for (int n = 1; n <= 16; n++) begin
        tick();
        for (int g = 0; g < 5; g++)
          if (done16[g] === 1'b1 && lat[g] < 0) lat[g] = n;
      end
      refSub(16, a16, b16, bin16, d, bo, ov);
      for (int g = 0; g < 5; g++) begin
        chk("sw_lat", lat[g], 16 >> g);
        chk("sw_diff", diff16[g], d);
        chk("sw_bout", bout16[g], bo);
        chk("sw_ovf", ovf16[g], ov);
        chk("sw_busy", busy16[g], 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
